// File: rtl/mux4_serializer_pkg.sv
// Shared types and constants for the 4-bit serializer and its select mux.
package mux4_serializer_pkg;

  localparam int unsigned SEL_W = 2;

  typedef enum logic [0:0] {
    IDLE,
    SHIFT
  } state_e;

  // Dwell counter width: max(1, clog2(dwell)).
  function automatic int unsigned cnt_width(input int unsigned dwell);
    return (dwell <= 2) ? 1 : $clog2(dwell);
  endfunction

endpackage

// File: rtl/mux4_serializer_mux4_1.sv
// Combinational 4:1 bit mux; {s1,s0} selects i0..i3.
module mux4_1 (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic s0,
  input  logic s1,
  output logic out
);

  always_comb begin
    out = 1'b0;
    unique case ({s1, s0})
      2'd0: out = i0;
      2'd1: out = i1;
      2'd2: out = i2;
      2'd3: out = i3;
    endcase
  end

endmodule

// File: rtl/mux4_serializer.sv
// Captures a 4-bit word on a ready/valid handshake and shifts it out one bit per
// DWELL accepted beats, driving the select of a 4:1 mux from a shadow register.
module mux4_serializer
  import mux4_serializer_pkg::*;
#(
  parameter int unsigned DWELL     = 1,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic in_valid,
  output logic in_ready,
  output logic out,
  output logic s0,
  output logic s1,
  output logic out_valid,
  input  logic out_ready,
  output logic last,
  output logic busy
);

  localparam int unsigned      CntW     = cnt_width(DWELL);
  localparam logic [CntW-1:0]  CntMax   = CntW'(DWELL - 1);
  localparam logic [SEL_W-1:0] SelFirst = MSB_FIRST ? 2'd3 : 2'd0;
  localparam logic [SEL_W-1:0] SelFinal = MSB_FIRST ? 2'd0 : 2'd3;
  // Adding 3 in a 2-bit field is a decrement.
  localparam logic [SEL_W-1:0] SelStep  = MSB_FIRST ? 2'd3 : 2'd1;

  state_e           state_q;
  logic [3:0]       shadow_q;
  logic [SEL_W-1:0] sel_q;
  logic [CntW-1:0]  cnt_q;

  logic shifting;
  logic dwell_done;
  logic beat;
  logic in_hs;
  logic mux_out;

  assign shifting   = (state_q == SHIFT);
  assign dwell_done = (cnt_q == CntMax);
  assign beat       = shifting && out_ready;
  assign last       = shifting && (sel_q == SelFinal) && dwell_done;
  // The last beat frees the shadow register, so a new word may land in the same cycle.
  assign in_ready   = !shifting || (last && out_ready);
  assign in_hs      = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
    end else if (in_hs) begin
      state_q  <= SHIFT;
      shadow_q <= {i3, i2, i1, i0};
      sel_q    <= SelFirst;
      cnt_q    <= '0;
    end else if (beat) begin
      if (!dwell_done) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (last) begin
        state_q <= IDLE;
        sel_q   <= '0;
        cnt_q   <= '0;
      end else begin
        sel_q <= sel_q + SelStep;
        cnt_q <= '0;
      end
    end
  end

  mux4_1 u_mux (
    .i0  (shadow_q[0]),
    .i1  (shadow_q[1]),
    .i2  (shadow_q[2]),
    .i3  (shadow_q[3]),
    .s0  (sel_q[0]),
    .s1  (sel_q[1]),
    .out (mux_out)
  );

  assign out       = shifting && mux_out;
  assign s0        = sel_q[0];
  assign s1        = sel_q[1];
  assign out_valid = shifting;
  assign busy      = shifting;

endmodule

// File: tb/tb_mux4_serializer.sv
// Scoreboard bench: three serializer instances (DWELL=1 LSB-first, DWELL=1 MSB-first,
// DWELL=3 LSB-first) with directed and random traffic.
module tb_mux4_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] word      [3];
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic       dout      [3];
  logic       s0        [3];
  logic       s1        [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic       last      [3];
  logic       busy      [3];
  int         rdy_mode  [3];
  int         acc_cnt   [3];
  int         exp_q     [3][$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int Dw = (g == 2) ? 3 : 1;
    localparam bit Mf = (g == 1);

    mux4_serializer #(
      .DWELL     (Dw),
      .MSB_FIRST (Mf)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i0        (word[g][0]),
      .i1        (word[g][1]),
      .i2        (word[g][2]),
      .i3        (word[g][3]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .out       (dout[g]),
      .s0        (s0[g]),
      .s1        (s1[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .last      (last[g]),
      .busy      (busy[g])
    );

    // Reference model + monitor: a word becomes 4*Dw expected beats {last,sel,bit}.
    initial begin : scoreboard
      int  e;
      int  idx;
      bit  hold_pend;
      int  hold_val;
      hold_pend = 1'b0;
      hold_val  = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          hold_pend = 1'b0;
        end else begin
          if (hold_pend) begin
            chk($sformatf("hold%0d {valid,sel,out}", g),
                {out_valid[g], s1[g], s0[g], dout[g]}, 8 + hold_val);
          end
          if (out_valid[g] && out_ready[g]) begin
            acc_cnt[g]++;
            if (exp_q[g].size() == 0) begin
              chk($sformatf("unexpected_beat%0d", g), 1, 0);
            end else begin
              e = exp_q[g].pop_front();
              chk($sformatf("beat%0d {last,sel,out}", g),
                  {last[g], s1[g], s0[g], dout[g]}, e);
            end
          end
          if (in_valid[g] && in_ready[g]) begin
            for (int b = 0; b < 4; b++) begin
              idx = Mf ? 3 - b : b;
              for (int k = 0; k < Dw; k++) begin
                exp_q[g].push_back(((b == 3 && k == Dw - 1) ? 8 : 0) + idx * 2 +
                                   int'(word[g][idx]));
              end
            end
          end
          hold_pend = out_valid[g] && !out_ready[g];
          hold_val  = {s1[g], s0[g], dout[g]};
        end
      end
    end

    initial begin : flush_on_reset
      forever begin
        @(negedge rst_n);
        exp_q[g].delete();
      end
    end

    initial begin : ready_driver
      out_ready[g] = 1'b1;
      forever begin
        @(posedge clk);
        #1;
        case (rdy_mode[g])
          0:       out_ready[g] = 1'b1;
          1:       out_ready[g] = ~out_ready[g];
          default: out_ready[g] = ($urandom_range(0, 3) != 0);
        endcase
      end
    end
  end

  task automatic send(input int g, input logic [3:0] w);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    word[g]     = w;
    in_valid[g] = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready[g]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk($sformatf("send_timeout%0d", g), 0, 1);
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
    word[g]     = 4'($urandom);  // must not disturb the word in flight
  endtask

  task automatic wait_idle(input int g, input int bound);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (!busy[g]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk($sformatf("idle_timeout%0d", g), 0, 1);
  endtask

  task automatic rand_traffic(input int g);
    for (int n = 0; n < 15; n++) begin
      send(g, 4'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
  endtask

  initial begin
    logic [3:0] w;
    int         base;
    int         contig;
    int         pend;
    bit         drained;

    rst_n = 1'b1;
    for (int g = 0; g < 3; g++) begin
      in_valid[g] = 1'b0;
      word[g]     = 4'b0;
      rdy_mode[g] = 0;
      acc_cnt[g]  = 0;
    end
    #1 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("reset%0d {valid,busy,last,sel,out}", g),
          {out_valid[g], busy[g], last[g], s1[g], s0[g], dout[g]}, 0);
      chk($sformatf("reset%0d in_ready", g), in_ready[g], 1);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Same word into LSB-first and MSB-first instances, out_ready tied high.
    w = 4'b1101;
    @(posedge clk);
    #1;
    word[0] = w; word[1] = w;
    in_valid[0] = 1'b1; in_valid[1] = 1'b1;
    @(negedge clk);
    chk("lsb in_ready idle", in_ready[0], 1);
    chk("msb in_ready idle", in_ready[1], 1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("lsb cyc%0d {valid,last,sel,out}", c),
          {out_valid[0], last[0], s1[0], s0[0], dout[0]},
          16 + ((c == 3) ? 8 : 0) + c * 2 + int'(w[c]));
      chk($sformatf("msb cyc%0d {valid,last,sel,out}", c),
          {out_valid[1], last[1], s1[1], s0[1], dout[1]},
          16 + ((c == 3) ? 8 : 0) + (3 - c) * 2 + int'(w[3 - c]));
    end
    @(negedge clk);
    chk("lsb done valid", out_valid[0], 0);
    chk("msb done valid", out_valid[1], 0);

    // DWELL=3 with toggling out_ready.
    rdy_mode[2] = 1;
    base = acc_cnt[2];
    send(2, 4'b0010);
    wait_idle(2, 200);
    chk("dwell3 accepted beats", acc_cnt[2] - base, 12);

    // Back-to-back words with in_valid held high.
    @(posedge clk);
    #1;
    word[0] = 4'b0011; in_valid[0] = 1'b1;
    @(negedge clk);
    chk("b2b in_ready A", in_ready[0], 1);
    @(posedge clk);
    #1;
    word[0] = 4'b1100;
    contig = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (out_valid[0]) contig++;
      if (c == 4) begin
        chk("b2b {in_ready,last} at A end", {in_ready[0], last[0]}, 3);
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
      end else if (c < 4) begin
        chk($sformatf("b2b in_ready mid A cyc%0d", c), in_ready[0], 0);
      end
    end
    chk("b2b contiguous valid", contig, 8);
    @(negedge clk);
    chk("b2b idle after B", out_valid[0], 0);

    // Reset after two accepted beats, then a fresh word right after release.
    rdy_mode[2] = 0;
    @(posedge clk);
    #1;
    word[0] = 4'b0110; in_valid[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset {valid,busy,last}", {out_valid[0], busy[0], last[0]}, 0);
    chk("midreset in_ready", in_ready[0], 1);
    chk("midreset {sel,out}", {s1[0], s0[0], dout[0]}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    word[0] = 4'b1111; in_valid[0] = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", in_ready[0], 1);
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("post-reset cyc%0d {valid,last,sel,out}", c),
          {out_valid[0], last[0], s1[0], s0[0], dout[0]},
          16 + ((c == 3) ? 8 : 0) + c * 2 + 1);
    end

    // Random words and random backpressure on all instances.
    for (int g = 0; g < 3; g++) rdy_mode[g] = 2;
    fork
      rand_traffic(0);
      rand_traffic(1);
      rand_traffic(2);
    join
    drained = 1'b0;
    pend    = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      pend = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
      if (pend == 0 && !busy[0] && !busy[1] && !busy[2]) begin
        drained = 1'b1;
        break;
      end
    end
    chk("drain pending beats", pend, 0);
    chk("drain completed", drained, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux4_serializer.md
MUX4_SERIALIZER -- requirements
Module: mux4_serializer

Interface
REQ-001 The block SHALL have parameter DWELL, default 1: number of accepted output beats per bit, legal range 1..16.
REQ-002 The block SHALL have parameter MSB_FIRST, default 0: 0 gives bit order i0,i1,i2,i3; 1 gives i3,i2,i1,i0.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports i0, i1, i2, i3, input, 1 bit each: parallel data word, sampled only on an input handshake.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can capture a word this cycle.
REQ-008 The block SHALL have port out, output, 1 bit: the serial data bit.
REQ-009 The block SHALL have ports s0 and s1, output, 1 bit each: the select currently applied, with s1 as MSB.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts a beat.
REQ-012 The block SHALL have port last, output, 1 bit: marks the final beat of the fourth bit.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the FSM is in state SHIFT.

Function
REQ-014 The block SHALL use a two-state FSM with states IDLE and SHIFT.
REQ-015 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
- An input handshake occurs when in_valid=1 and in_ready=1.
- On an input handshake, i0..i3 SHALL be captured into a 4-bit shadow register, sel SHALL be loaded with 0 (MSB_FIRST=0) or 3 (MSB_FIRST=1), the dwell counter SHALL clear, and the FSM SHALL enter SHIFT.
REQ-016 In SHIFT, out_valid SHALL be 1.
- out SHALL equal shadow[sel].
- {s1,s0} SHALL equal sel.
- Latency SHALL be one cycle: the first bit is presented the cycle after the input handshake.
REQ-017 A beat SHALL be accepted only when out_valid=1 and out_ready=1.
- While out_ready=0, sel, the dwell counter, the shadow register and out SHALL hold.
REQ-018 On each accepted beat, the dwell counter SHALL increment.
- When the counter equals DWELL-1, it SHALL wrap to 0 and sel SHALL step by +1 (MSB_FIRST=0) or -1 (MSB_FIRST=1).
REQ-019 last SHALL be 1 only in SHIFT, when sel is at its final value (3 or 0) and the dwell counter equals DWELL-1.
REQ-020 When the beat marked last is accepted, in_ready SHALL also be 1 in that same cycle.
- If in_valid=1 in that cycle, the new word SHALL be captured and SHIFT SHALL continue with no bubble.
- Otherwise the FSM SHALL return to IDLE.
REQ-021 In SHIFT, outside the last-accepted cycle, in_ready SHALL be 0, and i0..i3 changes SHALL NOT affect out.
REQ-022 The dwell counter width SHALL be max(1, clog2(DWELL)) bits.
- With DWELL=1, every accepted beat SHALL advance sel.
REQ-023 out, s0, s1, out_valid, last and busy SHALL be driven only from flops or from combinational logic of flops, with no path from i0..i3 to out.

Reset
REQ-024 While rst_n=0, the following SHALL hold immediately and asynchronously:
- FSM = IDLE
- shadow = 0, sel = 0, dwell counter = 0
- out = 0, s0 = 0, s1 = 0
- out_valid = 0, last = 0, busy = 0
- in_ready = 1
REQ-025 Reset asserted during SHIFT SHALL abort the word with no further beats.
- After rst_n rises, the block SHALL accept a new word on the first clk edge.

Structure
REQ-026 A shared package SHALL hold the FSM state typedef (IDLE, SHIFT) and the constant SEL_W = 2.
REQ-027 The data path SHALL instantiate one sub-module, mux4_1, a combinational 4:1 bit mux with inputs i0..i3, s0 and s1 and output out, driven from the shadow register and sel.

Verification
REQ-028 A bench SHALL run DWELL=1, MSB_FIRST=0, word i0..i3 = 1,0,1,1 with out_ready tied 1.
- Required: out = 1,0,1,1 on 4 consecutive cycles starting 1 cycle after the handshake.
- Required: {s1,s0} = 0,1,2,3, and last high only on cycle 4.
REQ-029 A bench SHALL run MSB_FIRST=1 with the same word.
- Required: out = 1,1,0,1 and {s1,s0} = 3,2,1,0.
REQ-030 A bench SHALL run DWELL=3 with word 0,1,0,0 and out_ready toggling 1,0,1,0...
- Required: each bit is held for exactly 3 accepted beats, for 12 accepted beats total.
- Required: out holds during out_ready=0 cycles.
REQ-031 A bench SHALL run back-to-back words A = 1,1,0,0 and B = 0,0,1,1 with in_valid held high.
- Required: 8 contiguous out_valid cycles, and in_ready pulses on the last beat of A.
REQ-032 A bench SHALL assert rst_n=0 mid-word, after 2 accepted beats.
- Required: out_valid, busy and last drop to 0 immediately, and in_ready = 1.
- Required: after release, a new word 1,1,1,1 serializes correctly from sel=0.
